kpn_fixed_addsub_node: RTL and testbench

- Parametrised KPN process node: pops one token from each of two input FIFOs, adds or subtracts them as signed two's-complement fixed-point values, and pushes the result to one output FIFO.
- Successor to the fixed 16-bit adder node. Adds configurable width, an add/sub mode, explicit FIFO empty/full handshakes, overflow detection and a token counter.
- Sits between KPN FIFO channels in the fixed-point module library.

---
 rtl/kpn_fixed_addsub_node.sv | 117 +++++++++++
 tb/tb_kpn_fixed_addsub_node.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kpn_fixed_addsub_node.sv
// kpn_fixed_addsub_node
//   KPN process node. It pops one token from each of two input FIFOs and
//   adds or subtracts them as signed two's-complement fixed-point values.
//   It then pushes the result to one output FIFO. The fraction point is
//   implicit and identical on all ports, so no alignment is done.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   entry_1, entry_2    FIFO data, valid in the cycle after rd_1/rd_2
//   empty_1, empty_2    input FIFO empty flags
//   full_out            output FIFO full flag
//   mode                0: entry_1 + entry_2, 1: entry_1 - entry_2
//   rd_1, rd_2          pop strobes (registered, high only in READ)
//   wr                  push strobe (WRITE and not full_out)
//   output_1            registered result token
//   overflow            sticky overflow flag, cleared only by reset
//   token_count         count of tokens written, wraps
//
// Build option:
//   KPN_ADDSUB_SATURATE_EN  when defined, an overflowing result clamps to
//                           the most-positive or most-negative value.
//                           When undefined, the result wraps modulo 2^WIDTH.

module kpn_fixed_addsub_node #(
    parameter int WIDTH       = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       entry_1,
    input  logic [WIDTH-1:0]       entry_2,
    input  logic                   empty_1,
    input  logic                   empty_2,
    input  logic                   full_out,
    input  logic                   mode,
    output logic                   rd_1,
    output logic                   rd_2,
    output logic                   wr,
    output logic [WIDTH-1:0]       output_1,
    output logic                   overflow,
    output logic [COUNT_WIDTH-1:0] token_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        WRITE   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   rd_q;
    logic [WIDTH-1:0]       out_q;
    logic                   ovf_q;
    logic [COUNT_WIDTH-1:0] cnt_q;

    logic [WIDTH:0]         a_ext, b_ext, sum;
    logic                   ovf;
    logic [WIDTH-1:0]       result;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty_1 && !empty_2) state_d = READ;
            READ:    state_d = CAPTURE;
            CAPTURE: state_d = WRITE;
            WRITE:   if (!full_out) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sign-extend both operands to WIDTH+1 bits so the extra bit holds the true sign.
    // Overflow is then simply a disagreement between the top two bits. This covers
    // the add rule and the subtract rule.
    always_comb begin
        a_ext  = {entry_1[WIDTH-1], entry_1};
        b_ext  = {entry_2[WIDTH-1], entry_2};
        sum    = mode ? (a_ext - b_ext) : (a_ext + b_ext);
        ovf    = sum[WIDTH] ^ sum[WIDTH-1];
`ifdef KPN_ADDSUB_SATURATE_EN
        if (ovf)
            result = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            result = sum[WIDTH-1:0];
`else
        result = sum[WIDTH-1:0];
`endif
    end

    assign wr = (state_q == WRITE) & ~full_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            // Register the strobe from the next state so it is high exactly while in READ.
            rd_q    <= (state_d == READ);
            if (state_q == CAPTURE) begin
                out_q <= result;
                ovf_q <= ovf_q | ovf;
            end
            if (wr) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign rd_1        = rd_q;
    assign rd_2        = rd_q;
    assign output_1    = out_q;
    assign overflow    = ovf_q;
    assign token_count = cnt_q;

endmodule

// File: tb/tb_kpn_fixed_addsub_node.sv
// Testbench for kpn_fixed_addsub_node (WIDTH=16, COUNT_WIDTH=16).
// The FIFOs on both sides are modelled with queues. Expected tokens come from
// integer arithmetic and are checked by a separate monitor process.

module tb_kpn_fixed_addsub_node;

    localparam int W  = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  entry_1 = '0, entry_2 = '0;
    logic          empty_1 = 1'b1, empty_2 = 1'b1;
    logic          full_out = 1'b0;
    logic          mode = 1'b0;
    logic          rd_1, rd_2, wr;
    logic [W-1:0]  output_1;
    logic          overflow;
    logic [CW-1:0] token_count;

    kpn_fixed_addsub_node #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .entry_1(entry_1), .entry_2(entry_2),
        .empty_1(empty_1), .empty_2(empty_2),
        .full_out(full_out), .mode(mode),
        .rd_1(rd_1), .rd_2(rd_2), .wr(wr),
        .output_1(output_1), .overflow(overflow), .token_count(token_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] val;
        logic         ovf;
    } exp_t;

    logic [W-1:0] q1[$], q2[$];
    logic         qm[$];
    exp_t         expq[$];

    int           compared = 0, mismatched = 0;
    int           cyc = 0, last_rd = 0, rd_pulses = 0, wr_pulses = 0;
    logic         bp_seen = 1'b0, cnt_chk = 1'b0, sticky = 1'b0;
    logic [CW-1:0] exp_cnt = '0;
    logic         rand_bp = 1'b0;

    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic m);
        exp_t e;
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = m ? sa - sb : sa + sb;
        e.ovf = (r > 32767) || (r < -32768);
        e.val = r[W-1:0];
`ifdef KPN_ADDSUB_SATURATE_EN
        if (e.ovf) e.val = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
        return e;
    endfunction

    task automatic push_token(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        q1.push_back(a);
        q2.push_back(b);
        qm.push_back(m);
        expq.push_back(model(a, b, m));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((expq.size() != 0 || q1.size() != 0 || q2.size() != 0) && n < bound) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        compared++;
        if (n >= bound) begin
            mismatched++;
            $display("FAIL drain_timeout: %0d tokens outstanding, expected 0", expq.size());
        end
    endtask

    // FIFO model: a pop strobe seen in a cycle presents the next data word in that same cycle.
    always @(posedge clk) begin
        #1;
        if (rst_n && rd_1) begin
            if (q1.size() == 0 || q2.size() == 0 || qm.size() == 0) begin
                mismatched++;
                $display("FAIL read_empty: rd with q1=%0d q2=%0d, expected nonempty", q1.size(), q2.size());
            end else begin
                entry_1 = q1.pop_front();
                entry_2 = q2.pop_front();
                mode    = qm.pop_front();
            end
        end
        empty_1 = (q1.size() == 0);
        empty_2 = (q2.size() == 0);
        if (rand_bp) full_out = ($urandom_range(0, 3) == 0);
    end

    // Monitor and scoreboard.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (cnt_chk) begin
            check("token_count", token_count, exp_cnt);
            cnt_chk = 1'b0;
        end
        if (rd_1 || rd_2) begin
            check("rd_pair", rd_2, rd_1);
            if (rd_1) begin
                last_rd = cyc;
                bp_seen = 1'b0;
                rd_pulses++;
            end
            if (wr) check("rd_wr_overlap", 1, 0);
        end
        if (wr) begin
            wr_pulses++;
            check("wr_while_full", full_out, 0);
            if (expq.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_wr: output_1=%0h, expected no write", output_1);
            end else begin
                e = expq.pop_front();
                sticky = sticky | e.ovf;
                check("output_1", output_1, e.val);
                check("overflow", overflow, sticky);
                if (bp_seen) check("latency_min", (cyc - last_rd) >= 2, 1);
                else         check("latency", cyc - last_rd, 2);
                exp_cnt = exp_cnt + 1'b1;
                cnt_chk = 1'b1;
            end
        end else if (full_out) begin
            bp_seen = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, wr0, n;
        exp_t e;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_rd", rd_1, 0);
        check("reset_wr", wr, 0);
        check("reset_out", output_1, 0);
        check("reset_ovf", overflow, 0);
        check("reset_cnt", token_count, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed tokens
        push_token(16'h0047, 16'h0065, 1'b0);
        drain(50);
        push_token(16'h0053, 16'h00C7, 1'b1);
        push_token(16'h0C84, 16'h0965, 1'b0);
        drain(50);
        push_token(16'h7000, 16'h2000, 1'b0);
        push_token(16'h0001, 16'h0001, 1'b0);
        push_token(16'h8000, 16'h0001, 1'b1);
        drain(50);

        // Starvation: only FIFO 1 holds data
        @(posedge clk); #1;
        rd0 = rd_pulses;
        q1.push_back(16'h1234);
        repeat (10) @(posedge clk);
        check("starve_no_rd", rd_pulses, rd0);
        #1;
        q2.push_back(16'h0102);
        qm.push_back(1'b1);
        expq.push_back(model(16'h1234, 16'h0102, 1'b1));
        drain(50);
        check("starve_one_rd", rd_pulses, rd0 + 1);

        // Backpressure
        @(posedge clk); #1;
        full_out = 1'b1;
        wr0 = wr_pulses;
        push_token(16'h4321, 16'hFEDC, 1'b0);
        e = model(16'h4321, 16'hFEDC, 1'b0);
        repeat (6) @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_out", output_1, e.val);
            check("bp_wr_low", wr, 0);
        end
        @(posedge clk); #1;
        full_out = 1'b0;
        drain(50);
        check("bp_one_wr", wr_pulses, wr0 + 1);

        // Randomized traffic with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            push_token(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
        end
        drain(2000);
        rand_bp = 1'b0;
        @(posedge clk); #1;
        full_out = 1'b0;

        // Reset during CAPTURE
        wr0 = wr_pulses;
        push_token(16'h0111, 16'h0222, 1'b0);
        n = 0;
        while (!rd_1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_rd_seen", rd_1, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_rd", rd_1, 0);
        check("abort_wr", wr, 0);
        check("abort_out", output_1, 0);
        check("abort_ovf", overflow, 0);
        check("abort_cnt", token_count, 0);
        if (expq.size() != 0) void'(expq.pop_back());
        sticky  = 1'b0;
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        check("abort_no_wr", wr_pulses, wr0);
        #1;
        push_token(16'h0010, 16'h0020, 1'b0);
        drain(50);
        check("post_reset_wr", wr_pulses, wr0 + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
